// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline types, widths and the MEM-stage FSM state.
package pipe_pkg;
    localparam int WORD_W = 32;
    localparam int RN_W = 5;
    typedef enum logic {IDLE, ACCESS} mem_state_t;
    typedef struct packed {
        logic              wreg;
        logic              m2reg;
        logic [WORD_W-1:0] mo;
        logic [WORD_W-1:0] alu;
        logic [RN_W-1:0]   rn;
    } memwb_t;
    function automatic logic [WORD_W-1:0] word_addr(input logic [WORD_W-1:0] a);
        return a & ~WORD_W'(3);
    endfunction
endpackage

// File: rtl/pipe_mem_stage_if.sv
// pipe_mem_stage_if: data-memory req/ack handshake between the MEM stage and memory.
interface pipe_mem_stage_if import pipe_pkg::*; ();
    logic              dmem_req;
    logic              dmem_we;
    logic [WORD_W-1:0] dmem_addr;
    logic [WORD_W-1:0] dmem_wdata;
    logic [WORD_W-1:0] dmem_rdata;
    logic              dmem_ack;
    modport master (output dmem_req, dmem_we, dmem_addr, dmem_wdata, input dmem_rdata, dmem_ack);
    modport slave  (input dmem_req, dmem_we, dmem_addr, dmem_wdata, output dmem_rdata, dmem_ack);
endinterface

// File: rtl/pipemwreg.sv
// pipemwreg: MEM/WB pipeline register with enable and bubble insertion.
module pipemwreg import pipe_pkg::*; (
    input  logic   clock,
    input  logic   reset,
    input  logic   en,
    input  logic   bubble,
    input  memwb_t d,
    output memwb_t q
);
    memwb_t wb_d, wb_q;
    always_comb wb_d = !en ? wb_q : bubble ? '0 : d;
    always_ff @(posedge clock or posedge reset)
        if (reset) wb_q <= '0;
        else       wb_q <= wb_d;
    assign q = wb_q;
endmodule

// File: rtl/pipe_mem_stage.sv
// pipe_mem_stage: MEM stage with variable-latency data-memory handshake and MEM/WB register.
// Define STORE_BUFFER_EN to add a one-entry posted store buffer with load forwarding.
module pipe_mem_stage import pipe_pkg::*; #(
    parameter int unsigned       TIMEOUT   = 255,
    parameter logic [WORD_W-1:0] ERR_RDATA = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mwreg,
    input  logic              mm2reg,
    input  logic              mwmem,
    input  logic [WORD_W-1:0] malu,
    input  logic [WORD_W-1:0] mb,
    input  logic [RN_W-1:0]   mrn,
    output logic              mem_stall,
    pipe_mem_stage_if.master  dmem,
    output logic              wwreg,
    output logic              wm2reg,
    output logic [WORD_W-1:0] wmo,
    output logic [WORD_W-1:0] walu,
    output logic [RN_W-1:0]   wrn,
    output logic              dmem_err
);
    mem_state_t        state_q, state_d;
    logic              req_q, req_d, we_q, we_d, err_q, err_d, drain_q, drain_d;
    logic [WORD_W-1:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [31:0]       cnt_q, cnt_d;
    logic              memop, is_load, acc, tmo, done, fwd, bubble;
    logic [WORD_W-1:0] rdata;
    memwb_t            wb, wb_q;

    assign memop   = mm2reg | mwmem;
    assign is_load = mm2reg & ~mwmem;
    assign acc     = state_q == ACCESS;
    assign tmo     = acc && TIMEOUT != 0 && cnt_q == TIMEOUT - 1 && !dmem.dmem_ack;
    assign done    = acc && (dmem.dmem_ack || tmo);
    assign rdata   = dmem.dmem_ack ? dmem.dmem_rdata : ERR_RDATA;
    assign fwd     = drain_q && is_load && word_addr(malu) == addr_q;

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        drain_d   = drain_q;
        err_d     = err_q | tmo;
        wb        = '{wreg: mwreg, m2reg: is_load, mo: '0, alu: malu, rn: mrn};
        bubble    = 1'b0;
        mem_stall = 1'b0;
        if (!acc) begin
            if (memop) begin
                state_d = ACCESS;
                req_d   = 1'b1;
                we_d    = mwmem;
                addr_d  = word_addr(malu);
                wdata_d = mb;
                cnt_d   = '0;
                bubble  = 1'b1;
`ifdef STORE_BUFFER_EN
                drain_d   = mwmem;
                mem_stall = !mwmem;
`else
                mem_stall = 1'b1;
`endif
            end
        end else if (drain_q) begin
            // Buffered store drains while non-conflicting work keeps flowing.
            cnt_d = done ? '0 : cnt_q + 32'd1;
            if (done) begin
                state_d = IDLE;
                req_d   = 1'b0;
                drain_d = 1'b0;
            end
            if (fwd) wb.mo = wdata_q;
            else if (memop) begin
                mem_stall = 1'b1;
                bubble    = 1'b1;
            end
        end else if (done) begin
            state_d = IDLE;
            req_d   = 1'b0;
            cnt_d   = '0;
            wb.mo   = is_load ? rdata : '0;
        end else begin
            mem_stall = 1'b1;
            bubble    = 1'b1;
            cnt_d     = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            drain_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
            err_q   <= err_d;
        end
    end

    pipemwreg u_mwreg (
        .clock  (clock),
        .reset  (reset),
        .en     (1'b1),
        .bubble (bubble),
        .d      (wb),
        .q      (wb_q)
    );

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign dmem_err        = err_q;
    assign wwreg           = wb_q.wreg;
    assign wm2reg          = wb_q.m2reg;
    assign wmo             = wb_q.mo;
    assign walu            = wb_q.alu;
    assign wrn             = wb_q.rn;
endmodule

// File: tb/tb_pipe_mem_stage.sv
// tb_pipe_mem_stage: directed self-checking bench for pipe_mem_stage (TIMEOUT=4).
module tb_pipe_mem_stage;
    import pipe_pkg::*;
    logic clock, reset, mwreg, mm2reg, mwmem, mem_stall, wwreg, wm2reg, dmem_err;
    logic [31:0] malu, mb, wmo, walu;
    logic [4:0] mrn, wrn;
    int checks = 0, errors = 0, nacc = 0, stall_cnt;

    pipe_mem_stage_if dif ();

    pipe_mem_stage #(.TIMEOUT(4), .ERR_RDATA(32'hDEAD_BEEF)) dut (
        .clock(clock), .reset(reset), .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem),
        .malu(malu), .mb(mb), .mrn(mrn), .mem_stall(mem_stall), .dmem(dif),
        .wwreg(wwreg), .wm2reg(wm2reg), .wmo(wmo), .walu(walu), .wrn(wrn), .dmem_err(dmem_err)
    );

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) if (dif.dmem_req && dif.dmem_ack) nacc++;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic wr, input logic ld, input logic st, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rn);
        mwreg = wr; mm2reg = ld; mwmem = st; malu = a; mb = b; mrn = rn;
        #1;
    endtask

    task automatic test_reset();
        dif.dmem_ack = 0; dif.dmem_rdata = 0;
        drive(0, 0, 0, 0, 0, 0);
        reset = 1;
        #12;
        checks++; if (wwreg !== 0 || wm2reg !== 0) begin errors++; $display("FAIL reset_wctl got %b%b exp 00", wwreg, wm2reg); end
        checks++; if ({wmo, walu, wrn} !== '0) begin errors++; $display("FAIL reset_wdata got %h %h %h exp 0", wmo, walu, wrn); end
        checks++; if (dif.dmem_req !== 0 || dif.dmem_we !== 0) begin errors++; $display("FAIL reset_req got %b%b exp 00", dif.dmem_req, dif.dmem_we); end
        checks++; if (dif.dmem_addr !== 0 || dif.dmem_wdata !== 0) begin errors++; $display("FAIL reset_addr got %h %h exp 0", dif.dmem_addr, dif.dmem_wdata); end
        checks++; if (dmem_err !== 0 || mem_stall !== 0) begin errors++; $display("FAIL reset_err_stall got %b%b exp 00", dmem_err, mem_stall); end
        @(posedge clock); #1 reset = 0;
    endtask

    task automatic test_alu();
        drive(1, 0, 0, 32'h1234, 0, 5'd8);
        checks++; if (mem_stall !== 0) begin errors++; $display("FAIL alu_stall got %b exp 0", mem_stall); end
        step();
        drive(0, 0, 0, 0, 0, 0);
        checks++; if (wwreg !== 1 || wm2reg !== 0) begin errors++; $display("FAIL alu_wctl got %b%b exp 10", wwreg, wm2reg); end
        checks++; if (walu !== 32'h1234 || wrn !== 5'd8 || wmo !== 0) begin errors++; $display("FAIL alu_wdata got %h %h %h exp 1234 08 0", walu, wrn, wmo); end
        checks++; if (dif.dmem_req !== 0) begin errors++; $display("FAIL alu_req got %b exp 0", dif.dmem_req); end
    endtask

    task automatic test_load();
        drive(1, 1, 0, 32'h0000_0103, 0, 5'd3);
        stall_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (mem_stall) stall_cnt++;
            if (i > 0) begin
                checks++; if (wwreg !== 0 || dif.dmem_req !== 1) begin errors++; $display("FAIL load_wait%0d got wwreg=%b req=%b exp 0 1", i, wwreg, dif.dmem_req); end
            end
            step();
        end
        checks++; if (stall_cnt !== 4) begin errors++; $display("FAIL load_stall_cycles got %0d exp 4", stall_cnt); end
        checks++; if (dif.dmem_addr !== 32'h100 || dif.dmem_we !== 0) begin errors++; $display("FAIL load_addr got %h we=%b exp 00000100 0", dif.dmem_addr, dif.dmem_we); end
        dif.dmem_ack = 1; dif.dmem_rdata = 32'hCAFE_F00D;
        #1;
        checks++; if (mem_stall !== 0) begin errors++; $display("FAIL load_ack_stall got %b exp 0", mem_stall); end
        step();
        dif.dmem_ack = 0;
        drive(0, 0, 0, 0, 0, 0);
        checks++; if (wwreg !== 1 || wm2reg !== 1 || wmo !== 32'hCAFE_F00D) begin errors++; $display("FAIL load_wb got %b%b %h exp 11 cafef00d", wwreg, wm2reg, wmo); end
        checks++; if (walu !== 32'h103 || wrn !== 5'd3 || dif.dmem_req !== 0 || dmem_err !== 0) begin errors++; $display("FAIL load_tail got %h %h req=%b err=%b exp 103 03 0 0", walu, wrn, dif.dmem_req, dmem_err); end
    endtask

    task automatic test_store();
        drive(0, 0, 1, 32'h200, 32'hA5A5_A5A5, 5'd0);
        checks++; if (mem_stall !== 1) begin errors++; $display("FAIL store_stall got %b exp 1", mem_stall); end
        step();
        checks++; if (dif.dmem_req !== 1 || dif.dmem_we !== 1) begin errors++; $display("FAIL store_req got %b%b exp 11", dif.dmem_req, dif.dmem_we); end
        checks++; if (dif.dmem_addr !== 32'h200 || dif.dmem_wdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL store_bus got %h %h exp 200 a5a5a5a5", dif.dmem_addr, dif.dmem_wdata); end
        dif.dmem_ack = 1; dif.dmem_rdata = 32'h7777_7777;
        #1;
        checks++; if (mem_stall !== 0) begin errors++; $display("FAIL store_ack_stall got %b exp 0", mem_stall); end
        step();
        dif.dmem_ack = 0;
        drive(0, 0, 0, 0, 0, 0);
        checks++; if (wwreg !== 0 || wm2reg !== 0 || wmo !== 0 || dif.dmem_req !== 0) begin errors++; $display("FAIL store_wb got %b%b %h req=%b exp 00 0 0", wwreg, wm2reg, wmo, dif.dmem_req); end
    endtask

    task automatic test_timeout();
        drive(1, 1, 0, 32'h40, 0, 5'd9);
        step();
        for (int i = 1; i <= 3; i++) begin
            checks++; if (mem_stall !== 1 || dif.dmem_req !== 1) begin errors++; $display("FAIL tmo_wait%0d got stall=%b req=%b exp 1 1", i, mem_stall, dif.dmem_req); end
            step();
        end
        checks++; if (mem_stall !== 0 || dmem_err !== 0) begin errors++; $display("FAIL tmo_last got stall=%b err=%b exp 0 0", mem_stall, dmem_err); end
        step();
        drive(0, 0, 0, 0, 0, 0);
        checks++; if (dmem_err !== 1 || dif.dmem_req !== 0) begin errors++; $display("FAIL tmo_err got err=%b req=%b exp 1 0", dmem_err, dif.dmem_req); end
        checks++; if (wmo !== 32'hDEAD_BEEF || wwreg !== 1 || wm2reg !== 1 || wrn !== 5'd9) begin errors++; $display("FAIL tmo_wb got %h %b%b %h exp deadbeef 11 09", wmo, wwreg, wm2reg, wrn); end
        drive(1, 0, 0, 32'h55, 0, 5'd2);
        checks++; if (mem_stall !== 0) begin errors++; $display("FAIL tmo_next_stall got %b exp 0", mem_stall); end
        step();
        drive(0, 0, 0, 0, 0, 0);
        checks++; if (walu !== 32'h55 || wwreg !== 1 || wmo !== 0 || dmem_err !== 1) begin errors++; $display("FAIL tmo_next got %h %b %h err=%b exp 55 1 0 1", walu, wwreg, wmo, dmem_err); end
    endtask

    task automatic test_reset_mid();
        drive(1, 1, 0, 32'h80, 0, 5'd7);
        step();
        checks++; if (dif.dmem_req !== 1) begin errors++; $display("FAIL rmid_req got %b exp 1", dif.dmem_req); end
        #2 reset = 1;
        #1;
        checks++; if (dif.dmem_req !== 0 || dmem_err !== 0) begin errors++; $display("FAIL rmid_async got req=%b err=%b exp 0 0", dif.dmem_req, dmem_err); end
        checks++; if ({wwreg, wm2reg, wmo, walu, wrn} !== '0) begin errors++; $display("FAIL rmid_w got %b%b %h %h %h exp 0", wwreg, wm2reg, wmo, walu, wrn); end
        drive(0, 0, 0, 0, 0, 0);
        step();
        reset = 0;
        dif.dmem_ack = 1; dif.dmem_rdata = 32'h1357_9BDF;
        step();
        dif.dmem_ack = 0;
        checks++; if (dif.dmem_req !== 0 || wwreg !== 0 || wm2reg !== 0 || wmo !== 0 || mem_stall !== 0) begin errors++; $display("FAIL rmid_stray got req=%b w=%b%b %h stall=%b exp 0 00 0 0", dif.dmem_req, wwreg, wm2reg, wmo, mem_stall); end
    endtask

    task automatic test_back_to_back();
        drive(1, 1, 0, 32'h100, 0, 5'd1);
        step();
        dif.dmem_ack = 1; dif.dmem_rdata = 32'hAAAA_0001;
        step();
        dif.dmem_ack = 0;
        drive(1, 1, 0, 32'h104, 0, 5'd2);
        checks++; if (wmo !== 32'hAAAA_0001 || wrn !== 5'd1) begin errors++; $display("FAIL b2b_first got %h %h exp aaaa0001 01", wmo, wrn); end
        checks++; if (dif.dmem_req !== 0 || mem_stall !== 1) begin errors++; $display("FAIL b2b_gap got req=%b stall=%b exp 0 1", dif.dmem_req, mem_stall); end
        step();
        checks++; if (dif.dmem_req !== 1 || dif.dmem_addr !== 32'h104) begin errors++; $display("FAIL b2b_second_req got %b %h exp 1 104", dif.dmem_req, dif.dmem_addr); end
        dif.dmem_ack = 1; dif.dmem_rdata = 32'hBBBB_0002;
        step();
        dif.dmem_ack = 0;
        drive(0, 0, 0, 0, 0, 0);
        checks++; if (wmo !== 32'hBBBB_0002 || wrn !== 5'd2 || wwreg !== 1) begin errors++; $display("FAIL b2b_second got %h %h %b exp bbbb0002 02 1", wmo, wrn, wwreg); end
    endtask

    task automatic test_store_buffer();
        int n0;
        n0 = nacc;
        drive(0, 0, 1, 32'h300, 32'h1234_5678, 5'd0);
        checks++; if (mem_stall !== 0) begin errors++; $display("FAIL sb_store_stall got %b exp 0", mem_stall); end
        step();
        drive(1, 1, 0, 32'h300, 0, 5'd4);
        checks++; if (dif.dmem_req !== 1 || dif.dmem_we !== 1 || wwreg !== 0) begin errors++; $display("FAIL sb_drain got req=%b we=%b wwreg=%b exp 1 1 0", dif.dmem_req, dif.dmem_we, wwreg); end
        checks++; if (mem_stall !== 0) begin errors++; $display("FAIL sb_fwd_stall got %b exp 0", mem_stall); end
        step();
        drive(0, 0, 0, 0, 0, 0);
        checks++; if (wmo !== 32'h1234_5678 || wm2reg !== 1 || wwreg !== 1) begin errors++; $display("FAIL sb_fwd got %h %b%b exp 12345678 11", wmo, wwreg, wm2reg); end
        dif.dmem_ack = 1;
        step();
        dif.dmem_ack = 0;
        step();
        checks++; if (dif.dmem_req !== 0 || nacc - n0 !== 1) begin errors++; $display("FAIL sb_requests got req=%b n=%0d exp 0 1", dif.dmem_req, nacc - n0); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
`ifdef STORE_BUFFER_EN
        test_store_buffer();
`else
        test_store();
`endif
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
